// File: rtl/heartbeat_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : heartbeat_tone_gen
// Brief    : Plays a "lub-dub" square-wave beep per heartbeat and streams
//            8-bit unsigned samples (128 = silence) to the PWM stage. Also
//            owns the user volume level from the debounced up/down buttons.
// Config   : HEARTBEAT_DUB_EN - when defined, the full LUB->GAP->DUB
//            sequence is built; otherwise only the LUB beep is played.
// Revision : 1.0 - initial release
// ============================================================================
module heartbeat_tone_gen #(
    parameter int SAMPLE_DIV   = 3125,
    parameter int HALF_PERIOD  = 4,
    parameter int BEEP_SAMPLES = 800,
    parameter int GAP_SAMPLES  = 400
) (
    input  logic       clock_25mhz,
    input  logic       reset_n,
    input  logic       beat,
    input  logic       volume_up,
    input  logic       volume_down,
    input  logic       mute,
    output logic [7:0] audio_data,
    output logic       busy,
    output logic [2:0] volume
);

    localparam int                 c_DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(SAMPLE_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE   = c_DIV_W'(1);
    localparam logic [15:0]        c_BEEP_LAST = 16'(BEEP_SAMPLES - 1);
    localparam logic [15:0]        c_HALF_LAST = 16'(HALF_PERIOD - 1);
`ifdef HEARTBEAT_DUB_EN
    localparam logic [15:0]        c_GAP_LAST   = 16'(GAP_SAMPLES - 1);
    localparam logic [15:0]        c_HALF2_LAST = 16'(2 * HALF_PERIOD - 1);
`endif
    localparam logic [7:0]         c_SILENCE   = 8'd128;

`ifdef HEARTBEAT_DUB_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LUB  = 2'd1,
        S_GAP  = 2'd2,
        S_DUB  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LUB  = 2'd1
    } state_t;
`endif

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_tick;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_smp_cnt;
    logic [15:0]        w_smp_nxt;
    logic [15:0]        r_half_cnt;
    logic [15:0]        w_half_nxt;
    logic               r_phase;
    logic               w_phase_nxt;
    logic [7:0]         r_audio;
    logic [7:0]         w_audio_nxt;
    logic [2:0]         r_volume;
    logic               r_up_d;
    logic               r_dn_d;
    logic               w_up_rise;
    logic               w_dn_rise;
    logic [7:0]         w_amp;
    logic [7:0]         w_tone_hi;
    logic [7:0]         w_tone_lo;
    logic [15:0]        w_smp_last;
    logic [15:0]        w_half_last;
    logic               w_tone_state;

    assign w_tick    = (r_div_cnt == c_DIV_LAST);
    assign w_amp     = {1'b0, r_volume, 4'b0000};
    assign w_tone_hi = c_SILENCE + w_amp;
    assign w_tone_lo = c_SILENCE - w_amp;
    assign w_up_rise = volume_up & ~r_up_d;
    assign w_dn_rise = volume_down & ~r_dn_d;

    // Free-running sample-rate divider; runs regardless of FSM state.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_ONE;
        end
    end

    // Per-state sample limits, half-period length and tone/silence select.
    always_comb begin
        w_smp_last   = c_BEEP_LAST;
        w_half_last  = c_HALF_LAST;
        w_tone_state = 1'b0;
        case (r_state)
            S_LUB: begin
                w_smp_last   = c_BEEP_LAST;
                w_tone_state = 1'b1;
            end
`ifdef HEARTBEAT_DUB_EN
            S_GAP: begin
                w_smp_last   = c_GAP_LAST;
            end
            S_DUB: begin
                w_smp_last   = c_BEEP_LAST;
                w_half_last  = c_HALF2_LAST;
                w_tone_state = 1'b1;
            end
`endif
            default: begin
                w_smp_last   = c_BEEP_LAST;
            end
        endcase
    end

    // Sequencer next-state logic plus the sample emitted on each tick.
    always_comb begin
        w_state_nxt = r_state;
        w_smp_nxt   = r_smp_cnt;
        w_half_nxt  = r_half_cnt;
        w_phase_nxt = r_phase;
        w_audio_nxt = r_audio;

        if (r_state == S_IDLE) begin
            if (beat) begin
                w_state_nxt = S_LUB;
                w_smp_nxt   = '0;
                w_half_nxt  = '0;
                w_phase_nxt = 1'b1;
            end
        end else if (w_tick) begin
            if (r_smp_cnt == w_smp_last) begin
                // Last sample of this state: every new state starts on high phase.
                w_smp_nxt   = '0;
                w_half_nxt  = '0;
                w_phase_nxt = 1'b1;
                case (r_state)
`ifdef HEARTBEAT_DUB_EN
                    S_LUB:   w_state_nxt = S_GAP;
                    S_GAP:   w_state_nxt = S_DUB;
`endif
                    default: w_state_nxt = S_IDLE;
                endcase
            end else begin
                w_smp_nxt = r_smp_cnt + 16'd1;
                if (w_tone_state) begin
                    if (r_half_cnt == w_half_last) begin
                        w_half_nxt  = '0;
                        w_phase_nxt = ~r_phase;
                    end else begin
                        w_half_nxt  = r_half_cnt + 16'd1;
                    end
                end
            end
        end

        // Mute only blanks the output; the sequence keeps its timing.
        if (w_tick) begin
            if (mute || !w_tone_state) begin
                w_audio_nxt = c_SILENCE;
            end else begin
                w_audio_nxt = r_phase ? w_tone_hi : w_tone_lo;
            end
        end
    end

    // Sequencer state, counters, phase and registered sample output.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_smp_cnt  <= '0;
            r_half_cnt <= '0;
            r_phase    <= 1'b1;
            r_audio    <= c_SILENCE;
        end else begin
            r_state    <= w_state_nxt;
            r_smp_cnt  <= w_smp_nxt;
            r_half_cnt <= w_half_nxt;
            r_phase    <= w_phase_nxt;
            r_audio    <= w_audio_nxt;
        end
    end

    // Button edge detect and saturating volume; simultaneous edges cancel.
    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_up_d   <= 1'b0;
            r_dn_d   <= 1'b0;
            r_volume <= 3'd4;
        end else begin
            r_up_d <= volume_up;
            r_dn_d <= volume_down;
            if (w_up_rise && !w_dn_rise && (r_volume != 3'd7)) begin
                r_volume <= r_volume + 3'd1;
            end else if (w_dn_rise && !w_up_rise && (r_volume != 3'd0)) begin
                r_volume <= r_volume - 3'd1;
            end
        end
    end

    assign audio_data = r_audio;
    assign busy       = (r_state != S_IDLE);
    assign volume     = r_volume;

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_heartbeat_tone_gen
// Brief    : Directed self-checking bench for heartbeat_tone_gen. Builds
//            for either setting of HEARTBEAT_DUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_heartbeat_tone_gen;

    localparam int c_DIV = 4;
`ifdef HEARTBEAT_DUB_EN
    localparam int c_N_SMP    = 15;
    localparam int c_BUSY_LEN = 60;
    localparam int c_BEAT_AT  = 7;   // inside GAP
    localparam int c_STOP_AT  = 11;  // inside DUB
    int sgn_tab [c_N_SMP] = '{1, 1, -1, -1, 1, 1, 0, 0, 0, 1, 1, 1, 1, -1, -1};
`else
    localparam int c_N_SMP    = 6;
    localparam int c_BUSY_LEN = 24;
    localparam int c_BEAT_AT  = 3;
    localparam int c_STOP_AT  = 4;
    int sgn_tab [c_N_SMP] = '{1, 1, -1, -1, 1, 1};
`endif

    logic       clock_25mhz;
    logic       reset_n;
    logic       beat;
    logic       volume_up;
    logic       volume_down;
    logic       mute;
    logic [7:0] audio_data;
    logic       busy;
    logic [2:0] volume;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cnt;
    int busy_cycles;
    bit busy_cnt_en = 1'b0;

    heartbeat_tone_gen #(
        .SAMPLE_DIV   (c_DIV),
        .HALF_PERIOD  (2),
        .BEEP_SAMPLES (6),
        .GAP_SAMPLES  (3)
    ) dut (
        .clock_25mhz (clock_25mhz),
        .reset_n     (reset_n),
        .beat        (beat),
        .volume_up   (volume_up),
        .volume_down (volume_down),
        .mute        (mute),
        .audio_data  (audio_data),
        .busy        (busy),
        .volume      (volume)
    );

    initial clock_25mhz = 1'b0;
    always #5 clock_25mhz = ~clock_25mhz;

    // Reference sample divider: value 3 means the next rising edge is a tick.
    always @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) tb_cnt <= 0;
        else          tb_cnt <= (tb_cnt == c_DIV - 1) ? 0 : tb_cnt + 1;
    end

    // Busy-length measurement, one count per low clock phase.
    always @(negedge clock_25mhz) begin
        if (busy_cnt_en && busy) busy_cycles <= busy_cycles + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Park on the low phase right before a tick edge.
    task automatic wait_tick_cycle();
        @(negedge clock_25mhz);
        while (tb_cnt != c_DIV - 1) @(negedge clock_25mhz);
    endtask

    task automatic vol_pulse(input logic up, input logic dn);
        volume_up   = up;
        volume_down = dn;
        @(negedge clock_25mhz);
        volume_up   = 1'b0;
        volume_down = 1'b0;
        @(negedge clock_25mhz);
    endtask

    // One beat, aligned so it is accepted on a tick edge; checks each sample.
    task automatic run_seq(input string tag, input int amp, input int mute_at,
                           input int beat_at, input int stop_at);
        int exp_v;
        busy_cycles = 0;
        busy_cnt_en = 1'b1;
        wait_tick_cycle();
        beat = 1'b1;
        @(negedge clock_25mhz);
        beat = 1'b0;
        check_eq({tag, "_busy_rise"}, int'(busy), 1);
        for (int i = 0; i < c_N_SMP; i++) begin
            if (i == stop_at) begin
                busy_cnt_en = 1'b0;
                return;
            end
            if (i == mute_at) mute = 1'b1;
            if (i == beat_at) begin
                beat = 1'b1;
                @(negedge clock_25mhz);
                beat = 1'b0;
            end
            wait_tick_cycle();
            @(negedge clock_25mhz);
            exp_v = (mute_at >= 0 && i >= mute_at) ? 128 : 128 + sgn_tab[i] * amp;
            check_eq($sformatf("%s_s%0d", tag, i), int'(audio_data), exp_v);
        end
        busy_cnt_en = 1'b0;
        check_eq({tag, "_busy_fall"}, int'(busy), 0);
        check_eq({tag, "_busy_len"}, busy_cycles, c_BUSY_LEN);
        mute = 1'b0;
        wait_tick_cycle();
        @(negedge clock_25mhz);
        check_eq({tag, "_idle_tick"}, int'(audio_data), 128);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        beat        = 1'b0;
        volume_up   = 1'b0;
        volume_down = 1'b0;
        mute        = 1'b0;
        repeat (3) @(negedge clock_25mhz);
        check_eq("rst_audio", int'(audio_data), 128);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_volume", int'(volume), 4);
        reset_n = 1'b1;
        repeat (2) begin
            wait_tick_cycle();
            @(negedge clock_25mhz);
            check_eq("idle_audio", int'(audio_data), 128);
        end

        // Volume 4: 192 / 64.
        run_seq("vol4", 64, -1, -1, -1);

        // Sweep up to saturation then down to zero.
        repeat (5) vol_pulse(1'b1, 1'b0);
        check_eq("vol_sat_hi", int'(volume), 7);
        run_seq("vol7", 112, -1, -1, -1);
        repeat (8) vol_pulse(1'b0, 1'b1);
        check_eq("vol_sat_lo", int'(volume), 0);
        run_seq("vol0", 0, -1, -1, -1);

        // Simultaneous edges cancel; held level steps once.
        vol_pulse(1'b1, 1'b0);
        check_eq("vol_up1", int'(volume), 1);
        vol_pulse(1'b1, 1'b1);
        check_eq("vol_both", int'(volume), 1);
        volume_up = 1'b1;
        repeat (100) @(negedge clock_25mhz);
        volume_up = 1'b0;
        @(negedge clock_25mhz);
        check_eq("vol_held", int'(volume), 2);

        // Extra beat mid-sequence is dropped; mute blanks without retiming.
        run_seq("beat_drop", 32, -1, c_BEAT_AT, -1);
        run_seq("mute", 32, 2, -1, -1);

        // Asynchronous reset mid-sequence, then a fresh sequence.
        run_seq("abort", 32, -1, -1, c_STOP_AT);
        #2 reset_n = 1'b0;
        #1;
        check_eq("abort_audio", int'(audio_data), 128);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_volume", int'(volume), 4);
        @(negedge clock_25mhz);
        reset_n = 1'b1;
        run_seq("fresh", 64, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
